// File: rtl/vmul_pkg.sv
// Shared types and defaults for the packed vector multiply sequencer.
package vmul_pkg;

   localparam int REG_WIDTH_DEF = 32;
   localparam int VLEN_DEF      = 128;

   typedef enum logic [1:0] {
      SEW_8   = 2'b00,
      SEW_16  = 2'b01,
      SEW_32  = 2'b10,
      SEW_ILL = 2'b11
   } sew_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_RESP
   } ctrl_state_e;

endpackage

// File: rtl/vmul_word_assembler.sv
// Result register filled one word per multiplier return, in return order.
module vmul_word_assembler
   import vmul_pkg::*;
#(
   parameter  int VLEN      = VLEN_DEF,
   parameter  int REG_WIDTH = REG_WIDTH_DEF,
   localparam int NWORDS    = VLEN / REG_WIDTH,
   localparam int CW        = $clog2(NWORDS + 1)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 clr,
   input  logic                 wr_en,
   input  logic [REG_WIDTH-1:0] wr_data,
   output logic [CW-1:0]        ret_cnt,
   output logic [VLEN-1:0]      res
);

   localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

   logic [NWORDS-1:0][REG_WIDTH-1:0] words;
   logic [CW-1:0]                    cnt;

   // Writes past the last word are dropped so the count saturates at NWORDS.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         words <= '0;
         cnt   <= '0;
      end else if (clr) begin
         words <= '0;
         cnt   <= '0;
      end else if (wr_en && (cnt < CW'(NWORDS))) begin
         words[cnt[IW-1:0]] <= wr_data;
         cnt                <= cnt + CW'(1);
      end
   end

   assign ret_cnt = cnt;
   assign res     = words;

   a_cnt_bound: assert property (@(posedge clk) disable iff (!reset_n) cnt <= CW'(NWORDS));

endmodule

// File: rtl/vmul_issue_ctrl.sv
// Slices two VLEN operands into words, issues them to the packed multiplier
// and holds the reassembled product until writeback takes it.
//
// state    | meaning
// ST_IDLE  | ready for a new operation
// ST_ISSUE | one word pair per cycle to the multiplier
// ST_DRAIN | all words issued, waiting for remaining returns
// ST_RESP  | result valid, waiting for res_ready_i
module vmul_issue_ctrl
   import vmul_pkg::*;
#(
   parameter int VLEN      = VLEN_DEF,
   parameter int REG_WIDTH = REG_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start_i,
   output logic                 ready_o,
   input  logic [1:0]           sew_i,
   input  logic [VLEN-1:0]      vs1_i,
   input  logic [VLEN-1:0]      vs2_i,
   output logic                 mul_valid_o,
   output logic [REG_WIDTH-1:0] mul_a_o,
   output logic [REG_WIDTH-1:0] mul_b_o,
   output logic [1:0]           mul_sew_o,
   input  logic                 mul_valid_i,
   input  logic [REG_WIDTH-1:0] mul_res_i,
   output logic                 res_valid_o,
   input  logic                 res_ready_i,
   output logic [VLEN-1:0]      res_o,
   output logic                 err_o
);

   localparam int NWORDS = VLEN / REG_WIDTH;
   localparam int CW     = $clog2(NWORDS + 1);
   localparam int IW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

   ctrl_state_e                      state, state_nxt;
   logic [NWORDS-1:0][REG_WIDTH-1:0] vs1_q, vs2_q;
   sew_e                             sew_q;
   logic                             err_q;
   logic [IW-1:0]                    iss_cnt;
   logic [CW-1:0]                    ret_cnt;
   logic                             accept, wr_en, ret_done, last_issue;

   assign accept     = start_i && (state == ST_IDLE);
   assign wr_en      = mul_valid_i && ((state == ST_ISSUE) || (state == ST_DRAIN));
   assign last_issue = (iss_cnt == IW'(NWORDS - 1));
   // Counts a return landing this cycle so a same-cycle final word skips DRAIN.
   assign ret_done   = (ret_cnt == CW'(NWORDS)) ||
                       (wr_en && (ret_cnt == CW'(NWORDS - 1)));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      ready_o     = 1'b0;
      mul_valid_o = 1'b0;
      res_valid_o = 1'b0;
      case (state)
         ST_IDLE: begin
            ready_o = 1'b1;
            if (start_i) begin
               state_nxt = (sew_i == SEW_ILL) ? ST_RESP : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            mul_valid_o = 1'b1;
            if (last_issue) begin
               state_nxt = ret_done ? ST_RESP : ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (ret_done) begin
               state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            res_valid_o = 1'b1;
            if (res_ready_i) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vs1_q   <= '0;
         vs2_q   <= '0;
         sew_q   <= SEW_8;
         err_q   <= 1'b0;
         iss_cnt <= '0;
      end else if (accept) begin
         vs1_q   <= vs1_i;
         vs2_q   <= vs2_i;
         sew_q   <= sew_e'(sew_i);
         err_q   <= (sew_i == SEW_ILL);
         iss_cnt <= '0;
      end else if (state == ST_ISSUE) begin
         iss_cnt <= iss_cnt + IW'(1);
      end
   end

   vmul_word_assembler #(
      .VLEN      (VLEN),
      .REG_WIDTH (REG_WIDTH)
   ) u_asm (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (accept),
      .wr_en   (wr_en),
      .wr_data (mul_res_i),
      .ret_cnt (ret_cnt),
      .res     (res_o)
   );

   assign mul_a_o   = mul_valid_o ? vs1_q[iss_cnt] : '0;
   assign mul_b_o   = mul_valid_o ? vs2_q[iss_cnt] : '0;
   assign mul_sew_o = sew_q;
   assign err_o     = err_q && res_valid_o;

   a_no_stray_ret: assert property (@(posedge clk) disable iff (!reset_n)
      mul_valid_i |-> ((state == ST_ISSUE) || (state == ST_DRAIN)));

endmodule

// File: tb/tb_vmul_issue_ctrl.sv
// Scoreboarded bench for vmul_issue_ctrl with a 0- or 2-cycle packed multiplier model.
module tb_vmul_issue_ctrl;

   localparam int VLEN = 128;
   localparam int RW   = 32;

   logic            clk, reset_n, start_i, ready_o;
   logic [1:0]      sew_i, mul_sew_o;
   logic [VLEN-1:0] vs1_i, vs2_i, res_o;
   logic            mul_valid_o, mul_valid_i, res_valid_o, res_ready_i, err_o;
   logic [RW-1:0]   mul_a_o, mul_b_o, mul_res_i;

   vmul_issue_ctrl #(.VLEN(VLEN), .REG_WIDTH(RW)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start_i     (start_i),
      .ready_o     (ready_o),
      .sew_i       (sew_i),
      .vs1_i       (vs1_i),
      .vs2_i       (vs2_i),
      .mul_valid_o (mul_valid_o),
      .mul_a_o     (mul_a_o),
      .mul_b_o     (mul_b_o),
      .mul_sew_o   (mul_sew_o),
      .mul_valid_i (mul_valid_i),
      .mul_res_i   (mul_res_i),
      .res_valid_o (res_valid_o),
      .res_ready_i (res_ready_i),
      .res_o       (res_o),
      .err_o       (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Packed multiplier model: lane-wise low-half products.
   function automatic logic [31:0] lane_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] sew);
      logic [31:0] r;
      logic [15:0] t8;
      logic [31:0] t16;
      logic [63:0] t32;
      r = '0;
      case (sew)
         2'b00: for (int i = 0; i < 4; i++) begin
            t8 = 16'(a[8*i +: 8]) * 16'(b[8*i +: 8]);
            r[8*i +: 8] = t8[7:0];
         end
         2'b01: for (int i = 0; i < 2; i++) begin
            t16 = 32'(a[16*i +: 16]) * 32'(b[16*i +: 16]);
            r[16*i +: 16] = t16[15:0];
         end
         default: begin
            t32 = 64'(a) * 64'(b);
            r = t32[31:0];
         end
      endcase
      return r;
   endfunction

   bit          lat0 = 1'b0;
   logic        p0_v, p1_v;
   logic [31:0] p0_d, p1_d;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         p0_v <= 1'b0; p1_v <= 1'b0; p0_d <= '0; p1_d <= '0;
      end else begin
         p0_v <= mul_valid_o;
         p0_d <= lane_mul(mul_a_o, mul_b_o, mul_sew_o);
         p1_v <= p0_v;
         p1_d <= p0_d;
      end
   end

   assign mul_valid_i = lat0 ? mul_valid_o : p1_v;
   assign mul_res_i   = lat0 ? lane_mul(mul_a_o, mul_b_o, mul_sew_o) : p1_d;

   typedef struct { logic [31:0] a; logic [31:0] b; logic [1:0] sew; } iss_t;
   typedef struct { logic [127:0] res; logic err; int lat; } res_t;
   iss_t iss_q[$];
   res_t res_q[$];
   iss_t exp_i;
   res_t exp_r;

   int acc_cyc = 0;
   int pulse_cnt = 0;
   bit saw_drain = 1'b0;
   bit prev_rv = 1'b0;

   // Monitor: pops expectations whenever the DUT presents an issue or a new result.
   always @(negedge clk) begin
      if (reset_n) begin
         if (mul_valid_o) begin
            pulse_cnt++;
            if (iss_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_issue: mul_a_o=%0h with no issue expected", mul_a_o);
            end else begin
               exp_i = iss_q.pop_front();
               chk("issue_a", mul_a_o, exp_i.a);
               chk("issue_b", mul_b_o, exp_i.b);
               chk("issue_sew", mul_sew_o, exp_i.sew);
            end
         end
         if (!ready_o && !mul_valid_o && !res_valid_o) saw_drain = 1'b1;
         if (res_valid_o && !prev_rv) begin
            if (res_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: res_o=%0h with no result expected", res_o);
            end else begin
               exp_r = res_q.pop_front();
               chk("result", res_o, exp_r.res);
               chk("result_err", err_o, exp_r.err);
               // cycles counted from the accept cycle (that cycle = 0)
               chk("result_latency", cyc - acc_cyc + 1, exp_r.lat);
            end
         end
      end
      prev_rv = res_valid_o && reset_n;
   end

   task automatic wait_resp(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (res_valid_o) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL resp_timeout: res_valid_o=0 after 40 cycles, required 1");
      end
   endtask

   task automatic issue_start(input logic [127:0] a, input logic [127:0] b, input logic [1:0] sew,
                              input bit zl, input bit rdy, input int n_iss,
                              input logic [127:0] exp_res, input int exp_lat, input bit push_res);
      @(negedge clk);
      lat0 = zl;
      vs1_i = a; vs2_i = b; sew_i = sew;
      start_i = 1'b1;
      res_ready_i = rdy;
      for (int i = 0; i < n_iss; i++) iss_q.push_back('{a[32*i +: 32], b[32*i +: 32], sew});
      if (push_res) res_q.push_back('{exp_res, (sew == 2'b11), exp_lat});
      pulse_cnt = 0;
      saw_drain = 1'b0;
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      start_i = 1'b0;
   endtask

   task automatic run_op(input logic [127:0] a, input logic [127:0] b, input logic [1:0] sew,
                         input bit zl, input int n_iss, input logic [127:0] exp_res,
                         input int exp_lat);
      bit ok;
      issue_start(a, b, sew, zl, 1'b1, n_iss, exp_res, exp_lat, 1'b1);
      wait_resp(ok);
      if (ok) begin
         @(negedge clk);
         chk("done_ready", ready_o, 1'b1);
         chk("done_res_valid", res_valid_o, 1'b0);
      end
      chk("issue_pulses", pulse_cnt, n_iss);
   endtask

   initial begin
      bit ok;
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit ok;
      reset_n = 1'b0;
      start_i = 1'($urandom);
      sew_i = 2'($urandom);
      vs1_i = {$urandom, $urandom, $urandom, $urandom};
      vs2_i = {$urandom, $urandom, $urandom, $urandom};
      res_ready_i = 1'($urandom);
      #22;
      chk("rst_ready", ready_o, 1'b1);
      chk("rst_mul_valid", mul_valid_o, 1'b0);
      chk("rst_res_valid", res_valid_o, 1'b0);
      chk("rst_res", res_o, '0);
      chk("rst_err", err_o, 1'b0);
      chk("rst_sew", mul_sew_o, 2'b00);
      @(negedge clk);
      start_i = 1'b0;
      reset_n = 1'b1;

      // SEW32, 2-cycle multiplier: goes through DRAIN
      run_op({32'd4, 32'd3, 32'd2, 32'd1}, {4{32'd10}}, 2'b10, 1'b0, 4,
             {32'd40, 32'd30, 32'd20, 32'd10}, 7);
      chk("sew32_drain_seen", saw_drain, 1'b1);

      // SEW8
      run_op(128'h04030201, 128'h02020202, 2'b00, 1'b0, 4, 128'h08060402, 7);
      chk("sew8_hold", mul_sew_o, 2'b00);

      // Illegal SEW: nothing issued, error response next cycle
      run_op({4{32'hDEADBEEF}}, {4{32'h12345678}}, 2'b11, 1'b0, 0, '0, 1);

      // SEW16, zero-latency multiplier: ISSUE straight to RESP
      run_op({32'h01000100, 32'hFFFF0002, 32'h00010001, 32'h00020003},
             {32'h01000100, 32'h00020003, 32'h00070009, 32'h00040005}, 2'b01, 1'b1, 4,
             {32'h00000000, 32'hFFFE0006, 32'h00070009, 32'h0008000F}, 5);
      chk("zl_no_drain", saw_drain, 1'b0);

      // Backpressure with ignored start
      issue_start({32'd8, 32'd6, 32'd4, 32'd2}, {4{32'd3}}, 2'b10, 1'b0, 1'b0, 4,
                  {32'd24, 32'd18, 32'd12, 32'd6}, 7, 1'b1);
      wait_resp(ok);
      for (int i = 0; i < 10; i++) begin
         chk("bp_res", res_o, {32'd24, 32'd18, 32'd12, 32'd6});
         chk("bp_ready", ready_o, 1'b0);
         chk("bp_valid", res_valid_o, 1'b1);
         if (i == 3) begin
            vs1_i = {4{32'h11111111}};
            sew_i = 2'b00;
            start_i = 1'b1;
         end
         if (i == 6) start_i = 1'b0;
         @(negedge clk);
      end
      start_i = 1'b0;
      res_ready_i = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", res_valid_o, 1'b0);
      chk("bp_release_ready", ready_o, 1'b1);
      chk("bp_sew_hold", mul_sew_o, 2'b10);

      // Abort during ISSUE: only word 0 is seen before reset
      issue_start({32'd5, 32'd6, 32'd7, 32'd9}, {4{32'd2}}, 2'b01, 1'b0, 1'b1, 1,
                  '0, 0, 1'b0);
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      chk("abort_ready", ready_o, 1'b1);
      chk("abort_mul_valid", mul_valid_o, 1'b0);
      chk("abort_res_valid", res_valid_o, 1'b0);
      chk("abort_res", res_o, '0);
      chk("abort_sew", mul_sew_o, 2'b00);
      @(negedge clk);
      reset_n = 1'b1;

      // Recovery after abort
      run_op({4{32'd1}}, {4{32'd9}}, 2'b10, 1'b1, 4, {4{32'd9}}, 5);

      repeat (3) @(negedge clk);
      chk("issue_q_empty", iss_q.size(), 0);
      chk("res_q_empty", res_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
